lab2_collect: RTL

Result collector that sits directly downstream of the lab2 compute blocks (multi-cycle and pipelined variants). It samples the 32-bit result `y` on every cycle the producer asserts `rdy` and buffers it in a small FIFO. Results are presented to a consumer over a valid/ready handshake. It also keeps a saturating drop counter and a running unsigned maximum of accepted results for bench-side checking.

---
 rtl/lab2_collect.sv | 87 ++++++++
 1 files changed

// File: rtl/lab2_collect.sv
// Result collector: buffers producer results in a show-ahead FIFO and tracks
// the overflow drop count and the running unsigned maximum of accepted results.
module lab2_collect #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     rdy,
  input  logic [WIDTH-1:0]         y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [WIDTH-1:0]         max_y
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push;
  logic             drop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign pop  = out_valid & out_ready;
  assign push = rdy & (!full | pop);
  assign drop = rdy & full & !pop;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      max_y    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        max_y  <= umax(y, max_y);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) begin
      mem[wr_ptr] <= y;
    end
  end

endmodule
